// File: rtl/dmem_unit.sv
// rtl/dmem_unit.sv - RISC-V data memory: lane stores, extended loads, clear sweep, counters
// Optional misaligned-access trapping is enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_unit #(
    parameter int DEPTH_WORDS = 128,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_w,
    input  logic             mem_r,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic [2:0]       dm_type,
    output logic [31:0]      rdata,
    output logic             busy,
    output logic             fault,
    output logic [31:0]      fault_addr,
    output logic [15:0]      load_cnt,
    output logic [15:0]      store_cnt,
    input  logic [IDX_W-1:0] dbg_idx,
    output logic [31:0]      dbg_data
);

    localparam logic S_CLEAR = 1'b0;
    localparam logic S_IDLE  = 1'b1;

    logic [31:0]      mem_q [DEPTH_WORDS];
    logic             state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [15:0]      load_cnt_q, load_cnt_d;
    logic [15:0]      store_cnt_q, store_cnt_d;
    logic             fault_q, fault_d;
    logic [31:0]      fault_addr_q, fault_addr_d;

    logic [IDX_W-1:0] idx;
    logic [1:0]       off;
    logic [31:0]      cur_word;
    logic             is_half, is_byte, is_word, is_signed;
    logic             misal, trap;
    logic [3:0]       be;
    logic [31:0]      st_data, merged;
    logic [31:0]      shifted, load_ext;
    logic [15:0]      half_v;
    logic [7:0]       byte_v;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [31:0]      wr_word;

    always_comb begin
        idx       = addr[IDX_W+1:2];
        off       = addr[1:0];
        cur_word  = mem_q[idx];
        is_half   = (dm_type == 3'b001) || (dm_type == 3'b010);
        is_byte   = (dm_type == 3'b011) || (dm_type == 3'b100);
        is_word   = !is_half && !is_byte;
        is_signed = (dm_type == 3'b001) || (dm_type == 3'b011);
        misal     = (is_half && off[0]) || (is_word && (off != 2'b00));
`ifdef DMEM_MISALIGN_TRAP_EN
        trap      = misal;
`else
        trap      = 1'b0;
`endif

        // Half accesses pick their lane pair from off[1] only, so off[0] is don't-care when not trapping
        if (is_word)      be = 4'hF;
        else if (is_half) be = off[1] ? 4'hC : 4'h3;
        else              be = 4'b0001 << off;

        if (is_word)      st_data = wdata;
        else if (is_half) st_data = {2{wdata[15:0]}};
        else              st_data = {4{wdata[7:0]}};

        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = be[i] ? st_data[8*i +: 8] : cur_word[8*i +: 8];
        end

        shifted = cur_word >> {off, 3'b000};
        byte_v  = shifted[7:0];
        half_v  = off[1] ? cur_word[31:16] : cur_word[15:0];
        if (is_byte)      load_ext = {{24{is_signed & byte_v[7]}}, byte_v};
        else if (is_half) load_ext = {{16{is_signed & half_v[15]}}, half_v};
        else              load_ext = cur_word;

        rdata = ((state_q == S_IDLE) && !trap) ? load_ext : 32'h0;

        if (state_q == S_CLEAR) begin
            wr_en   = 1'b1;
            wr_idx  = ptr_q;
            wr_word = 32'h0;
        end else begin
            wr_en   = mem_w && !trap;
            wr_idx  = idx;
            wr_word = merged;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        load_cnt_d   = load_cnt_q;
        store_cnt_d  = store_cnt_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        if (state_q == S_CLEAR) begin
            ptr_d = ptr_q + IDX_W'(1);
            if (ptr_q == IDX_W'(DEPTH_WORDS - 1)) state_d = S_IDLE;
        end else begin
            if (mem_r) load_cnt_d  = load_cnt_q + 16'd1;
            if (mem_w) store_cnt_d = store_cnt_q + 16'd1;
            if (trap && (mem_r || mem_w)) begin
                fault_d = 1'b1;
                if (!fault_q) fault_addr_d = addr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_CLEAR;
            ptr_q        <= '0;
            load_cnt_q   <= 16'h0;
            store_cnt_q  <= 16'h0;
            fault_q      <= 1'b0;
            fault_addr_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            load_cnt_q   <= load_cnt_d;
            store_cnt_q  <= store_cnt_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    // Array is deliberately not reset; the sweep clears it one word per cycle
    always_ff @(posedge clk) begin
        if (!reset && wr_en) mem_q[wr_idx] <= wr_word;
    end

`ifndef DMEM_MISALIGN_TRAP_EN
    logic unused_addr_hi;
    assign unused_addr_hi = ^{addr[31:IDX_W+2], misal};
`endif

    assign busy       = (state_q == S_CLEAR);
    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;
    assign load_cnt   = load_cnt_q;
    assign store_cnt  = store_cnt_q;
    assign dbg_data   = mem_q[dbg_idx];

endmodule
